// File: rtl/apb_regbank_slave_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and one register-bank
// completer (slave). Clock and reset travel as plain ports beside it.
interface apb_regbank_slave_if;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface : apb_regbank_slave_if

// File: rtl/apb_regbank_slave.sv
// APB completer on one Pselx line of the AHB-to-APB bridge.
// Register map (word index from Paddr[AW+1:2]):
//   0 .. NUM_REGS-3 : read/write, reset 0
//   NUM_REGS-2      : WCOUNT, read-only count of committed writes
//   NUM_REGS-1      : ID, read-only constant ID_VALUE
// Unaligned accesses and writes to the read-only registers complete with
// Pslverr and change nothing. WAIT_CYCLES wait states are inserted in ACCESS.
module apb_regbank_slave #(
  parameter int          SLV_INDEX   = 0,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                      Pclk,
  input  logic                      Preset,
  apb_regbank_slave_if.slave        bus
);

  localparam int AW     = $clog2(NUM_REGS);
  localparam int NUM_RW = NUM_REGS - 2;

  localparam logic [AW-1:0] IDX_WCOUNT = AW'(NUM_REGS - 2);
  localparam logic [AW-1:0] IDX_ID     = AW'(NUM_REGS - 1);
  localparam logic [3:0]    WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State and latched transfer attributes
  // ---------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_wcnt;
  logic [AW-1:0]   r_idx;
  logic            r_write;
  logic [31:0]     r_wdata;
  logic            r_err;
  logic [31:0]     r_rdata;
  logic [31:0]     r_regs [NUM_RW];
  logic [31:0]     r_wcount;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic            w_sel;
  logic [AW-1:0]   w_idx;
  logic            w_ro_hit;
  logic            w_err_in;
  logic [31:0]     w_rd_mux;
  logic [31:0]     w_rdata_setup;
  logic            w_setup;
  logic            w_pready;
  logic            w_commit;
  logic            w_wcnt_dec;
  logic            w_unused;

  assign w_sel    = bus.Pselx[SLV_INDEX];
  assign w_idx    = bus.Paddr[AW+1:2];
  assign w_ro_hit = (w_idx == IDX_WCOUNT) || (w_idx == IDX_ID);
  assign w_err_in = (bus.Paddr[1:0] != 2'b00) || (bus.Pwrite && w_ro_hit);

  // Upper address bits and the other slaves' select lines are deliberately ignored.
  assign w_unused = ^{bus.Paddr, bus.Pselx};

  // Read mux for the address presented in SETUP; an erroring access returns 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned, which is what would otherwise infer a latch.
    w_rd_mux = '0;
    if (w_idx == IDX_ID) begin
      w_rd_mux = ID_VALUE;
    end else if (w_idx == IDX_WCOUNT) begin
      w_rd_mux = r_wcount;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (w_idx == AW'(i)) begin
          w_rd_mux = r_regs[i];
        end
      end
    end
  end

  assign w_rdata_setup = w_err_in ? 32'h0 : w_rd_mux;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // Next-state decode: SETUP detection, completion and abort.
  always_comb begin
    w_state_nxt = r_state;
    w_setup     = 1'b0;
    w_pready    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Penable without a preceding SETUP is ignored here.
        if (w_sel && !bus.Penable) begin
          w_setup     = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!w_sel) begin
          // Select dropped before completion: abandon the transfer.
          w_state_nxt = S_IDLE;
        end else if (bus.Penable && (r_wcnt == 4'd0)) begin
          w_pready    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_commit   = w_pready && r_write && !r_err;
  assign w_wcnt_dec = (r_state == S_ACCESS) && w_sel && bus.Penable &&
                      (r_wcnt != 4'd0);

  // State register.
  always_ff @(posedge Pclk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (Preset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the transfer in SETUP and count down wait states in ACCESS.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      r_wcnt  <= 4'd0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else if (w_setup) begin
      r_wcnt  <= WAIT_INIT;
      r_idx   <= w_idx;
      r_write <= bus.Pwrite;
      r_wdata <= bus.Pwdata;
      r_err   <= w_err_in;
      r_rdata <= w_rdata_setup;
    end else if (w_wcnt_dec) begin
      r_wcnt  <= r_wcnt - 4'd1;
    end
  end

  // Register bank and write counter, updated only on a clean write completion.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      // NOTE: the register array is reset explicitly because software relies on
      // reading zero after reset; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < NUM_RW; i++) begin
        r_regs[i] <= 32'h0;
      end
      r_wcount <= 32'h0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (r_idx == AW'(i)) begin
          r_regs[i] <= r_wdata;
        end
      end
      r_wcount <= r_wcount + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.Pready  = w_pready;
  assign bus.Pslverr = w_pready && r_err;
  assign bus.Prdata  = (w_pready && !r_write) ? r_rdata : 32'h0;

endmodule : apb_regbank_slave

// File: tb/tb_apb_regbank_slave.sv
// Directed bench for apb_regbank_slave. Three instances share one APB bus,
// each on its own Pselx bit with a different wait-state count:
//   slave 0: WAIT_CYCLES=1, slave 1: WAIT_CYCLES=0, slave 2: WAIT_CYCLES=3.
// A vector table covers the register map, errors, latency and back-to-back
// transfers; hand sequences cover abort, Penable-without-SETUP and mid-transfer reset.
module tb_apb_regbank_slave;

  logic        pclk;
  logic        preset;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;

  int total = 0;
  int bad   = 0;

  apb_regbank_slave_if u_if0 ();
  apb_regbank_slave_if u_if1 ();
  apb_regbank_slave_if u_if2 ();

  assign u_if0.Pselx = pselx;  assign u_if0.Penable = penable;
  assign u_if0.Pwrite = pwrite; assign u_if0.Paddr = paddr; assign u_if0.Pwdata = pwdata;
  assign u_if1.Pselx = pselx;  assign u_if1.Penable = penable;
  assign u_if1.Pwrite = pwrite; assign u_if1.Paddr = paddr; assign u_if1.Pwdata = pwdata;
  assign u_if2.Pselx = pselx;  assign u_if2.Penable = penable;
  assign u_if2.Pwrite = pwrite; assign u_if2.Paddr = paddr; assign u_if2.Pwdata = pwdata;

  apb_regbank_slave #(.SLV_INDEX(0), .WAIT_CYCLES(1)) u_dut0 (
    .Pclk(pclk), .Preset(preset), .bus(u_if0.slave));
  apb_regbank_slave #(.SLV_INDEX(1), .WAIT_CYCLES(0)) u_dut1 (
    .Pclk(pclk), .Preset(preset), .bus(u_if1.slave));
  apb_regbank_slave #(.SLV_INDEX(2), .WAIT_CYCLES(3)) u_dut2 (
    .Pclk(pclk), .Preset(preset), .bus(u_if2.slave));

  logic [31:0] prdata_a  [3];
  logic        pready_a  [3];
  logic        pslverr_a [3];

  assign prdata_a[0] = u_if0.Prdata; assign pready_a[0] = u_if0.Pready; assign pslverr_a[0] = u_if0.Pslverr;
  assign prdata_a[1] = u_if1.Prdata; assign pready_a[1] = u_if1.Pready; assign pslverr_a[1] = u_if1.Pslverr;
  assign prdata_a[2] = u_if2.Prdata; assign pready_a[2] = u_if2.Pready; assign pslverr_a[2] = u_if2.Pslverr;

  // ACCESS cycle in which Pready rises, per slave (WAIT_CYCLES + 1).
  int exp_cyc [3] = '{2, 1, 4};

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    pselx   = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
  endtask

  // One APB transfer to slave d. Returns with the bus still driven in the
  // completing cycle so a following call forms a back-to-back transfer.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd,
                      output logic er, output int cyc);
    bit done;
    done = 1'b0;
    rd   = 32'h0;
    er   = 1'b0;
    cyc  = 0;
    @(negedge pclk);
    pselx   = 3'(1 << d);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(negedge pclk);
    penable = 1'b1;
    for (int n = 1; n <= 20 && !done; n++) begin
      #1;
      if (pready_a[d]) begin
        done = 1'b1;
        cyc  = n;
        rd   = prdata_a[d];
        er   = pslverr_a[d];
      end else begin
        @(negedge pclk);
      end
    end
    if (!done) begin
      check("xfer_timeout", 32'd0, 32'd1);
      bus_idle();
    end
  endtask

  typedef struct {
    int          dut;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [27];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;
    bit          seen;

    vecs[0]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[2]  = '{0, 1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{0, 1'b0, 32'h0000_0018, 32'h0,         32'h1,         1'b0};
    vecs[4]  = '{0, 1'b0, 32'h0000_001C, 32'h0,         32'hA5B0_0001, 1'b0};
    vecs[5]  = '{0, 1'b1, 32'h0000_001C, 32'h1234,      32'h0,         1'b1};
    vecs[6]  = '{0, 1'b0, 32'h0000_001C, 32'h0,         32'hA5B0_0001, 1'b0};
    vecs[7]  = '{0, 1'b0, 32'h0000_0018, 32'h0,         32'h1,         1'b0};
    vecs[8]  = '{0, 1'b1, 32'h0000_0006, 32'h55,        32'h0,         1'b1};
    vecs[9]  = '{0, 1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{0, 1'b0, 32'h0000_0006, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{0, 1'b1, 32'h0000_0018, 32'h7,         32'h0,         1'b1};
    vecs[12] = '{0, 1'b0, 32'h0000_0018, 32'h0,         32'h1,         1'b0};
    vecs[13] = '{0, 1'b1, 32'hFFFF_FF14, 32'h0BAD_F00D, 32'h0,         1'b0};
    vecs[14] = '{0, 1'b0, 32'h0000_0014, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[15] = '{0, 1'b0, 32'h0000_0018, 32'h0,         32'h2,         1'b0};
    vecs[16] = '{1, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0,         1'b0};
    vecs[17] = '{1, 1'b1, 32'h0000_0008, 32'h2222_2222, 32'h0,         1'b0};
    vecs[18] = '{1, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
    vecs[19] = '{1, 1'b0, 32'h0000_0008, 32'h0,         32'h2222_2222, 1'b0};
    vecs[20] = '{1, 1'b0, 32'h0000_0018, 32'h0,         32'h2,         1'b0};
    vecs[21] = '{2, 1'b1, 32'h0000_0000, 32'h0000_000A, 32'h0,         1'b0};
    vecs[22] = '{2, 1'b1, 32'h0000_0008, 32'h0000_000B, 32'h0,         1'b0};
    vecs[23] = '{2, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_000A, 1'b0};
    vecs[24] = '{2, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_000B, 1'b0};
    vecs[25] = '{2, 1'b0, 32'h0000_0018, 32'h0,         32'h2,         1'b0};
    vecs[26] = '{2, 1'b0, 32'h0000_001C, 32'h0,         32'hA5B0_0001, 1'b0};

    // Reset: two cycles, then all outputs quiet.
    bus_idle();
    preset = 1'b1;
    repeat (2) @(negedge pclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_pready%0d", d),  32'(pready_a[d]),  32'h0);
      check($sformatf("rst_pslverr%0d", d), 32'(pslverr_a[d]), 32'h0);
      check($sformatf("rst_prdata%0d", d),  prdata_a[d],       32'h0);
    end
    preset = 1'b0;

    // Table: consecutive vectors run back-to-back with no idle cycle.
    for (int i = 0; i < 27; i++) begin
      xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, cyc);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i),   32'(er), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(exp_cyc[vecs[i].dut]));
    end
    @(negedge pclk);
    bus_idle();

    // Abort: slave 2 write loses its select during wait states.
    @(negedge pclk);
    pselx = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hCAFE_F00D;
    @(negedge pclk);
    penable = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      #1 seen |= pready_a[2];
      @(negedge pclk);
    end
    bus_idle();
    repeat (3) begin
      #1 seen |= pready_a[2];
      @(negedge pclk);
    end
    check("abort_no_pready", 32'(seen), 32'h0);
    xfer(2, 1'b0, 32'h4, 32'h0, rd, er, cyc);
    check("abort_no_write", rd, 32'h0);
    xfer(2, 1'b0, 32'h18, 32'h0, rd, er, cyc);
    check("abort_wcount", rd, 32'h2);
    @(negedge pclk);
    bus_idle();

    // Penable asserted with no SETUP phase: slave 0 must stay silent.
    @(negedge pclk);
    pselx = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h99;
    seen = 1'b0;
    repeat (6) begin
      #1 seen |= pready_a[0] | pslverr_a[0];
      @(negedge pclk);
    end
    bus_idle();
    check("nosetup_no_resp", 32'(seen), 32'h0);
    xfer(0, 1'b0, 32'h0, 32'h0, rd, er, cyc);
    check("nosetup_no_write", rd, 32'h0);
    xfer(0, 1'b0, 32'h18, 32'h0, rd, er, cyc);
    check("nosetup_wcount", rd, 32'h2);
    @(negedge pclk);
    bus_idle();

    // Reset in the first ACCESS cycle of a slave 0 write.
    @(negedge pclk);
    pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h77;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    check("rstmid_pre_pready", 32'(pready_a[0]), 32'h0);
    preset = 1'b1;
    @(negedge pclk);
    #1;
    check("rstmid_pready",  32'(pready_a[0]),  32'h0);
    check("rstmid_pslverr", 32'(pslverr_a[0]), 32'h0);
    check("rstmid_prdata",  prdata_a[0],       32'h0);
    preset = 1'b0;
    bus_idle();
    xfer(0, 1'b0, 32'h0, 32'h0, rd, er, cyc);
    check("rstmid_idx0", rd, 32'h0);
    xfer(0, 1'b0, 32'h4, 32'h0, rd, er, cyc);
    check("rstmid_idx1", rd, 32'h0);
    xfer(0, 1'b0, 32'h14, 32'h0, rd, er, cyc);
    check("rstmid_idx5", rd, 32'h0);
    xfer(0, 1'b0, 32'h18, 32'h0, rd, er, cyc);
    check("rstmid_wcount", rd, 32'h0);
    xfer(1, 1'b0, 32'h0, 32'h0, rd, er, cyc);
    check("rstmid_s1_idx0", rd, 32'h0);
    @(negedge pclk);
    bus_idle();
    repeat (2) @(negedge pclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule : tb_apb_regbank_slave
